// File: rtl/bram_stream_reader.sv
// bram_stream_reader: read-side master for a dual-port no-change BRAM.
// Takes a (start address, length) command, issues credit-limited reads and
// streams the returned words over valid/ready with last-beat and done flags.
module bram_stream_reader #(
    parameter int unsigned C_RAM_WIDTH = 64,
    parameter int unsigned C_RAM_DEPTH = 512,
    parameter string       C_RAM_PERF  = "LOW_LATENCY"
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [$clog2(C_RAM_DEPTH)-1:0]   cmd_addr,
    input  logic [$clog2(C_RAM_DEPTH):0]     cmd_len,
    output logic [$clog2(C_RAM_DEPTH)-1:0]   ram_addr,
    output logic                             ram_rden,
    input  logic [C_RAM_WIDTH-1:0]           ram_dout,
    output logic [C_RAM_WIDTH-1:0]           dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic                             dout_last,
    output logic                             done,
    output logic                             busy
);

    localparam int unsigned A  = $clog2(C_RAM_DEPTH);
    // BRAM read latency in rden-qualified stages
    localparam int unsigned L  = (C_RAM_PERF == "HIGH_PERFORMANCE") ? 3 : 1;
    // Credit pool: FIFO entries plus reads in flight
    localparam int unsigned D  = L + 2;
    localparam int unsigned PW = $clog2(D);
    localparam int unsigned CW = $clog2(D + 1);
    localparam int unsigned SW = CW + 1;

    localparam logic [A-1:0]  LastAddr = A'(C_RAM_DEPTH - 1);
    localparam logic [PW-1:0] LastPtr  = PW'(D - 1);
    localparam logic [A:0]    One      = 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_t;

    state_t                 r_state;
    logic [A-1:0]           r_addr_cnt;
    logic [A-1:0]           r_ram_addr;
    logic                   r_ram_rden;
    logic                   r_done;
    logic [A:0]             r_remaining;
    logic [A:0]             r_len;
    logic [A:0]             r_beat;
    // Bit 0 tracks the read held on ram_addr; bits 1..L follow it through the BRAM stages
    logic [L:0]             r_tag;

    logic [C_RAM_WIDTH-1:0] r_fifo [D];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_fcount;

    logic                   w_accept;
    logic                   w_issue;
    logic                   w_wr;
    logic                   w_pop;
    logic                   w_last;
    logic [CW-1:0]          w_inflight;
    logic [SW-1:0]          w_sum;
    logic [SW-1:0]          w_limit;

    function automatic logic [A-1:0] next_addr(input logic [A-1:0] a);
        return (a == LastAddr) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign w_inflight = CW'($countones(r_tag));
    assign w_accept   = (r_state == StIdle) && cmd_valid;
    assign w_pop      = dout_valid && dout_ready;
    assign w_wr       = r_tag[L];
    assign w_sum      = SW'(r_fcount) + SW'(w_inflight);
    // A pop this cycle frees a slot, so it counts as credit for the issue decision
    assign w_limit    = SW'(D) + SW'(w_pop);
    assign w_issue    = (w_accept && (cmd_len != '0)) ||
                        ((r_state == StIssue) && (r_remaining != '0) && (w_sum < w_limit));
    assign w_last     = (r_beat + One) == r_len;

    assign cmd_ready  = (r_state == StIdle);
    assign busy       = (r_state != StIdle);
    assign ram_addr   = r_ram_addr;
    assign ram_rden   = r_ram_rden;
    assign done       = r_done;
    assign dout_valid = (r_fcount != '0);
    assign dout       = r_fifo[r_rptr];
    assign dout_last  = dout_valid && w_last;

    // Command FSM: read issue, address/remaining counters, tag pipe, beat count, done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_addr_cnt  <= '0;
            r_ram_addr  <= '0;
            r_ram_rden  <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_tag       <= '0;
        end else begin
            r_done <= 1'b0;
            r_tag  <= {r_tag[L-1:0], w_issue};
            if (w_pop) begin
                r_beat <= r_beat + One;
            end
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_len  <= cmd_len;
                        r_beat <= '0;
                        if (cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            // First read goes out on the accept edge itself
                            r_ram_addr  <= cmd_addr;
                            r_ram_rden  <= 1'b1;
                            r_addr_cnt  <= next_addr(cmd_addr);
                            r_remaining <= cmd_len - One;
                            r_state     <= (cmd_len == One) ? StDrain : StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (w_issue) begin
                        r_ram_addr  <= r_addr_cnt;
                        r_addr_cnt  <= next_addr(r_addr_cnt);
                        r_remaining <= r_remaining - One;
                        if (r_remaining == One) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (w_pop && w_last) begin
                        r_state    <= StIdle;
                        r_ram_rden <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // FIFO storage: captures BRAM data when a tagged read leaves the pipe
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_fifo[r_wptr] <= ram_dout;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_fcount <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            case ({w_wr, w_pop})
                2'b10:   r_fcount <= r_fcount + 1'b1;
                2'b01:   r_fcount <= r_fcount - 1'b1;
                default: r_fcount <= r_fcount;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: runs a LOW_LATENCY and a HIGH_PERFORMANCE reader side by
// side on shared command/ready inputs, each with its own BRAM model.
module tb_bram_stream_reader;

    localparam int DEPTH = 512;
    localparam int CAP   = 600;

    typedef struct {
        int addr;
        int len;
        bit rnd;
        int exp_first;
        int exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [8:0]  cmd_addr;
    logic [9:0]  cmd_len;
    logic        dout_ready;

    logic        cmd_ready  [2];
    logic [8:0]  ram_addr   [2];
    logic        ram_rden   [2];
    logic [63:0] dout       [2];
    logic        dout_valid [2];
    logic        dout_last  [2];
    logic        done       [2];
    logic        busy       [2];
    logic [63:0] ram_dout_ll;
    logic [63:0] ram_dout_hp;
    logic [63:0] hp_p1;
    logic [63:0] hp_p2;

    logic [63:0] mem [DEPTH];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    logic [63:0] cap_data [2][CAP];
    logic        cap_last [2][CAP];
    int          cap_edge [2][CAP];
    int          cap_n    [2];
    int          done_n   [2];
    int          done_cyc [2];
    int          first_v  [2];
    logic        any_valid  [2];
    logic        stall_prev [2];
    logic [63:0] prev_data  [2];
    logic        prev_last  [2];

    vec_t        vecs [8];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bram_stream_reader #(
        .C_RAM_WIDTH (64),
        .C_RAM_DEPTH (DEPTH),
        .C_RAM_PERF  ("LOW_LATENCY")
    ) dut_ll (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready[0]),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .ram_addr   (ram_addr[0]),
        .ram_rden   (ram_rden[0]),
        .ram_dout   (ram_dout_ll),
        .dout       (dout[0]),
        .dout_valid (dout_valid[0]),
        .dout_ready (dout_ready),
        .dout_last  (dout_last[0]),
        .done       (done[0]),
        .busy       (busy[0])
    );

    bram_stream_reader #(
        .C_RAM_WIDTH (64),
        .C_RAM_DEPTH (DEPTH),
        .C_RAM_PERF  ("HIGH_PERFORMANCE")
    ) dut_hp (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready[1]),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .ram_addr   (ram_addr[1]),
        .ram_rden   (ram_rden[1]),
        .ram_dout   (ram_dout_hp),
        .dout       (dout[1]),
        .dout_valid (dout_valid[1]),
        .dout_ready (dout_ready),
        .dout_last  (dout_last[1]),
        .done       (done[1]),
        .busy       (busy[1])
    );

    // BRAM models: one rden-qualified stage vs three
    always @(posedge clk) begin
        if (ram_rden[0]) ram_dout_ll <= mem[ram_addr[0]];
    end

    always @(posedge clk) begin
        if (ram_rden[1]) begin
            hp_p1       <= mem[ram_addr[1]];
            hp_p2       <= hp_p1;
            ram_dout_hp <= hp_p2;
        end
    end

    // Word stored at an address: low half is the address itself
    function automatic logic [63:0] model_word(input int a);
        return {32'(a) ^ 32'h5A5A_0000, 32'(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clear_mon();
        for (int k = 0; k < 2; k++) begin
            cap_n[k]     = 0;
            done_n[k]    = 0;
            done_cyc[k]  = -1;
            first_v[k]   = -1;
            any_valid[k] = 1'b0;
        end
    endtask

    // Stream monitor, sampled mid-cycle
    initial begin
        for (int k = 0; k < 2; k++) stall_prev[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (stall_prev[k]) begin
                    check($sformatf("k%0d stall valid", k), 64'(dout_valid[k]), 64'd1);
                    check($sformatf("k%0d stall data", k), dout[k], prev_data[k]);
                    check($sformatf("k%0d stall last", k), 64'(dout_last[k]), 64'(prev_last[k]));
                end
                if (dout_valid[k]) begin
                    any_valid[k] = 1'b1;
                    if (first_v[k] < 0) first_v[k] = cyc;
                end
                if (dout_valid[k] && dout_ready) begin
                    if (cap_n[k] < CAP) begin
                        cap_data[k][cap_n[k]] = dout[k];
                        cap_last[k][cap_n[k]] = dout_last[k];
                        cap_edge[k][cap_n[k]] = cyc + 1;
                    end
                    cap_n[k]++;
                end
                if (done[k]) begin
                    done_n[k]++;
                    done_cyc[k] = cyc;
                end
                stall_prev[k] = dout_valid[k] && !dout_ready && !rst;
                prev_data[k]  = dout[k];
                prev_last[k]  = dout_last[k];
            end
            check("ll credit bound",
                  64'((int'(dut_ll.r_fcount) + int'(dut_ll.w_inflight)) <= 3), 64'd1);
            check("hp credit bound",
                  64'((int'(dut_hp.r_fcount) + int'(dut_hp.w_inflight)) <= 5), 64'd1);
        end
    end

    task automatic run_cmd(input int addr, input int len, input bit rnd);
        int t0;
        int lat;
        bit finished;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d cmd_ready idle", k), 64'(cmd_ready[k]), 64'd1);
        end
        clear_mon();
        dout_ready = rnd ? ($urandom_range(99) < 30) : 1'b1;
        cmd_valid  = 1'b1;
        cmd_addr   = 9'(addr);
        cmd_len    = 10'(len);
        @(posedge clk); #1;
        t0        = cyc;
        cmd_valid = 1'b0;
        finished  = 1'b0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            if (done_n[0] > 0 && done_n[1] > 0) finished = 1'b1;
            else begin
                @(posedge clk); #1;
                dout_ready = rnd ? ($urandom_range(99) < 30) : 1'b1;
            end
        end
        check($sformatf("a%0d l%0d completes", addr, len), 64'(finished), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 2 : 4;
            check($sformatf("k%0d a%0d beat count", k, addr), 64'(cap_n[k]), 64'(len));
            for (int i = 0; i < len && i < cap_n[k] && i < CAP; i++) begin
                check($sformatf("k%0d a%0d beat%0d data", k, addr, i),
                      cap_data[k][i], model_word((addr + i) % DEPTH));
                check($sformatf("k%0d a%0d beat%0d last", k, addr, i),
                      64'(cap_last[k][i]), 64'(i == len - 1));
            end
            check($sformatf("k%0d a%0d done count", k, addr), 64'(done_n[k]), 64'd1);
            if (len == 0) begin
                check($sformatf("k%0d len0 no valid", k), 64'(any_valid[k]), 64'd0);
                check($sformatf("k%0d len0 done cycle", k), 64'(done_cyc[k]), 64'(t0));
            end else if (cap_n[k] >= len) begin
                check($sformatf("k%0d a%0d done cycle", k, addr),
                      64'(done_cyc[k]), 64'(cap_edge[k][len-1]));
                if (!rnd) begin
                    check($sformatf("k%0d a%0d first valid", k, addr),
                          64'(first_v[k]), 64'(t0 + lat));
                    check($sformatf("k%0d a%0d no bubbles", k, addr),
                          64'(cap_edge[k][len-1] - cap_edge[k][0]), 64'(len - 1));
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{addr: 10,  len: 4,   rnd: 1'b0, exp_first: 10,  exp_last: 13};
        vecs[1] = '{addr: 0,   len: 8,   rnd: 1'b0, exp_first: 0,   exp_last: 7};
        vecs[2] = '{addr: 510, len: 4,   rnd: 1'b0, exp_first: 510, exp_last: 1};
        vecs[3] = '{addr: 0,   len: 16,  rnd: 1'b1, exp_first: 0,   exp_last: 15};
        vecs[4] = '{addr: 300, len: 16,  rnd: 1'b1, exp_first: 300, exp_last: 315};
        vecs[5] = '{addr: 7,   len: 0,   rnd: 1'b0, exp_first: -1,  exp_last: -1};
        vecs[6] = '{addr: 0,   len: 512, rnd: 1'b0, exp_first: 0,   exp_last: 511};
        vecs[7] = '{addr: 505, len: 1,   rnd: 1'b0, exp_first: 505, exp_last: 505};

        for (int i = 0; i < DEPTH; i++) mem[i] = model_word(i);

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        dout_ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d reset cmd_ready", k), 64'(cmd_ready[k]), 64'd1);
            check($sformatf("k%0d reset busy", k), 64'(busy[k]), 64'd0);
            check($sformatf("k%0d reset rden", k), 64'(ram_rden[k]), 64'd0);
            check($sformatf("k%0d reset ram_addr", k), 64'(ram_addr[k]), 64'd0);
            check($sformatf("k%0d reset valid", k), 64'(dout_valid[k]), 64'd0);
            check($sformatf("k%0d reset last", k), 64'(dout_last[k]), 64'd0);
            check($sformatf("k%0d reset done", k), 64'(done[k]), 64'd0);
        end

        foreach (vecs[v]) begin
            run_cmd(vecs[v].addr, vecs[v].len, vecs[v].rnd);
            for (int k = 0; k < 2; k++) begin
                if (vecs[v].len > 0 && cap_n[k] >= vecs[v].len) begin
                    check($sformatf("k%0d vec%0d first word", k, v),
                          64'(cap_data[k][0][8:0]), 64'(vecs[v].exp_first));
                    check($sformatf("k%0d vec%0d last word", k, v),
                          64'(cap_data[k][vecs[v].len-1][8:0]), 64'(vecs[v].exp_last));
                end
            end
        end

        repeat (6) begin
            run_cmd(int'($urandom_range(DEPTH - 1)), int'($urandom_range(40, 1)), 1'b1);
        end

        // Reset in the middle of a len=20 command
        @(posedge clk); #1;
        clear_mon();
        dout_ready = 1'b1;
        cmd_valid  = 1'b1;
        cmd_addr   = 9'd0;
        cmd_len    = 10'd20;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 100 && cap_n[0] < 5; c++) begin
            @(posedge clk); #1;
        end
        check("reach beat 5 before reset", 64'(cap_n[0] >= 5), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d midreset cmd_ready", k), 64'(cmd_ready[k]), 64'd1);
            check($sformatf("k%0d midreset busy", k), 64'(busy[k]), 64'd0);
            check($sformatf("k%0d midreset valid", k), 64'(dout_valid[k]), 64'd0);
            check($sformatf("k%0d midreset last", k), 64'(dout_last[k]), 64'd0);
            check($sformatf("k%0d midreset done", k), 64'(done[k]), 64'd0);
            check($sformatf("k%0d midreset rden", k), 64'(ram_rden[k]), 64'd0);
        end
        #1 clear_mon();
        repeat (8) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d post-reset no done", k), 64'(done_n[k]), 64'd0);
            check($sformatf("k%0d post-reset no valid", k), 64'(any_valid[k]), 64'd0);
        end
        run_cmd(100, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
